// File: rtl/tff_count_sequencer_pkg.sv
// Shared definitions for the toggle-cell counter sequencer: FSM state encodings.
package tff_count_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/tff_count_sequencer_if.sv
// Control bus between the sequencing master and the counter sequencer.
interface tff_count_sequencer_if #(
  parameter int WIDTH = 8
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             dir;
  logic [WIDTH-1:0] limit;
  logic             abort;
  logic             busy;
  logic             done;
  logic             tc;
  logic [WIDTH-1:0] count;

  modport master (
    output load, load_val, start, dir, limit, abort,
    input  busy, done, tc, count
  );

  modport slave (
    input  load, load_val, start, dir, limit, abort,
    output busy, done, tc, count
  );

endinterface

// File: rtl/tff_count_sequencer_t_ff.sv
// Single toggle cell: q flips on every rising edge where t is high.
module tff_count_sequencer_t_ff (
  input  logic clk,
  input  logic rstn,
  input  logic t,
  output logic q,
  output logic q_bar
);

  logic q_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q <= 1'b0;
    end else if (t) begin
      q_q <= ~q_q;
    end
  end

  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: rtl/tff_count_sequencer.sv
// Up/down counter built from a bank of toggle cells; this block only decides
// which cells toggle each cycle, the count itself lives in the cells.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting; load toggles differing bits, start launches a run
//   RUN     | stepping toward limit_q in direction dir_q (busy high)
//   DONE    | one-cycle completion pulse, then back to IDLE
//   (2'd3)  | illegal, recovers to IDLE
module tff_count_sequencer
  import tff_count_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rstn,
  tff_count_sequencer_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] count_w;
  logic [WIDTH-1:0] t_up, t_dn, t_vec;
  logic             at_limit, at_wrap;

  always_comb begin : step_vectors
    logic carry_up;
    logic carry_dn;
    carry_up = 1'b1;
    carry_dn = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_up[i]  = carry_up;
      t_dn[i]  = carry_dn;
      carry_up = carry_up & count_w[i];
      carry_dn = carry_dn & ~count_w[i];
    end
  end

  assign at_limit = (count_w == limit_q);
  assign at_wrap  = dir_q ? (&count_w) : ~(|count_w);

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    dir_d   = dir_q;
    t_vec   = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          t_vec = count_w ^ bus.load_val;
        end else if (bus.start) begin
          limit_d = bus.limit;
          dir_d   = bus.dir;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // abort wins over the terminal compare
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (at_limit) begin
          state_d = ST_DONE;
        end else begin
          t_vec = dir_q ? t_up : t_dn;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      dir_q   <= dir_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_count_sequencer_t_ff u_cell (
      .clk   (clk),
      .rstn  (rstn),
      .t     (t_vec[i]),
      .q     (count_w[i]),
      .q_bar ()
    );
  end

  assign bus.count = count_w;
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.tc    = (state_q == ST_RUN) & ~bus.abort & ~at_limit & at_wrap;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Bench for tff_count_sequencer: directed scenarios plus random traffic,
// every cycle checked against an arithmetic model of the counter.
module tb_tff_count_sequencer;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  // model: phase 0=idle 1=run 2=done
  int m_ph;
  int m_count;
  int m_limit;
  int m_dir;

  tff_count_sequencer_if #(.WIDTH(W)) bus ();

  tff_count_sequencer #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ph = 0; m_count = 0; m_limit = 0; m_dir = 1;
    end else begin
      case (m_ph)
        0: begin
          if (bus.load) m_count = int'(bus.load_val);
          else if (bus.start) begin
            m_limit = int'(bus.limit);
            m_dir   = int'(bus.dir);
            m_ph    = 1;
          end
        end
        1: begin
          if (bus.abort) m_ph = 0;
          else if (m_count == m_limit) m_ph = 2;
          else m_count = (m_count + (m_dir != 0 ? 1 : MASK)) & MASK;
        end
        default: m_ph = 0;
      endcase
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    int wrap;
    wrap = (m_dir != 0) ? int'(m_count == MASK) : int'(m_count == 0);
    chk("count", int'(bus.count), m_count);
    chk("busy", int'(bus.busy), int'(m_ph == 1));
    chk("done", int'(bus.done), int'(m_ph == 2));
    chk("tc", int'(bus.tc),
        int'(m_ph == 1 && !bus.abort && m_count != m_limit && wrap != 0));
  endtask

  // inputs are set just after a falling edge; this checks, then advances one cycle
  task automatic tick();
    #1 compare();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load = 0; bus.load_val = '0; bus.start = 0;
    bus.dir = 1; bus.limit = '0; bus.abort = 0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    bus.load = 1; bus.load_val = v;
    tick();
    bus.load = 0;
  endtask

  task automatic do_start(input logic d, input logic [W-1:0] lim);
    bus.start = 1; bus.dir = d; bus.limit = lim;
    tick();
    bus.start = 0;
  endtask

  initial begin
    int nb, ntc, ndone, prev;
    logic [W-1:0] dn_seq [5];
    total = 0; bad = 0;
    dn_seq[0] = 8'h02; dn_seq[1] = 8'h01; dn_seq[2] = 8'h00;
    dn_seq[3] = 8'hFF; dn_seq[4] = 8'hFE;
    idle_inputs();
    rstn = 0;
    #23;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    @(negedge clk); #1;
    rstn = 1;
    tick();

    // up run 0..5
    do_load(8'h00);
    do_start(1'b1, 8'h05);
    nb = 0;
    for (int k = 0; k < 20 && bus.busy; k++) begin
      chk("up_seq", int'(bus.count), k);
      nb++;
      tick();
    end
    chk("up_busy_cycles", nb, 6);
    chk("up_done", int'(bus.done), 1);
    chk("up_hold", int'(bus.count), 5);
    tick();
    chk("up_done_width", int'(bus.done), 0);

    // down run through zero
    do_load(8'h02);
    do_start(1'b0, 8'hFE);
    nb = 0; ntc = 0;
    for (int k = 0; k < 20 && bus.busy; k++) begin
      if (k < 5) chk("dn_seq", int'(bus.count), int'(dn_seq[k]));
      if (bus.tc) begin
        chk("dn_tc_at", int'(bus.count), 0);
        ntc++;
      end
      nb++;
      tick();
    end
    chk("dn_busy_cycles", nb, 5);
    chk("dn_tc_pulses", ntc, 1);
    chk("dn_done", int'(bus.done), 1);
    tick();

    // load by toggling every bit
    do_load(8'hA5);
    prev = int'(bus.count);
    do_load(8'h5A);
    chk("load_val", int'(bus.count), 8'h5A);
    chk("load_toggles", prev ^ int'(bus.count), 8'hFF);
    chk("load_busy", int'(bus.busy), 0);

    // abort at 0x07
    do_load(8'h00);
    do_start(1'b1, 8'h10);
    for (int k = 0; k < 40 && bus.count != 8'h07; k++) tick();
    chk("abort_reach", int'(bus.count), 8'h07);
    bus.abort = 1;
    tick();
    bus.abort = 0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_count", int'(bus.count), 8'h07);
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.done) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0);

    // load and start together: load wins
    bus.load = 1; bus.load_val = 8'h33; bus.start = 1; bus.limit = 8'h80;
    tick();
    bus.load = 0; bus.start = 0;
    chk("conf_busy", int'(bus.busy), 0);
    chk("conf_count", int'(bus.count), 8'h33);
    tick();
    chk("conf_still_idle", int'(bus.busy), 0);

    // start with limit == count, then start during DONE
    do_start(1'b1, 8'h33);
    chk("eq_busy", int'(bus.busy), 1);
    tick();
    chk("eq_done", int'(bus.done), 1);
    bus.start = 1; bus.limit = 8'h40;
    tick();
    bus.start = 0;
    chk("done_start_ign", int'(bus.busy), 0);
    tick();
    chk("done_start_ign2", int'(bus.busy), 0);

    // asynchronous reset mid-run at 0x37
    do_load(8'h30);
    do_start(1'b1, 8'h50);
    for (int k = 0; k < 40 && bus.count != 8'h37; k++) tick();
    chk("rst_reach", int'(bus.count), 8'h37);
    #2 rstn = 0;
    #1;
    chk("arst_count", int'(bus.count), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_tc", int'(bus.tc), 0);
    @(negedge clk); #1;
    rstn = 1;
    tick();

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      bus.load     = ($urandom_range(0, 7) == 0);
      bus.load_val = W'($urandom);
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.dir      = 1'($urandom);
      if ($urandom_range(0, 2) == 0) bus.limit = W'($urandom);
      else if (bus.dir) bus.limit = W'(m_count + $urandom_range(0, 12));
      else bus.limit = W'(m_count - $urandom_range(0, 12));
      bus.abort    = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 499) == 0) rstn = 0;
      tick();
      rstn = 1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
